// File: rtl/otter_arb_pkg.sv
// Shared types and constants for the OTTER data-memory arbiter.
// Provides the arbiter state encoding, master indices and lock-counter helpers.
package otter_arb_pkg;

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam logic M_HART = 1'b0;
  localparam logic M_AUX  = 1'b1;

  localparam int LOCK_CNT_W = 8;

  // Saturating increment so a long wait never wraps back below the timeout.
  function automatic logic [LOCK_CNT_W-1:0] sat_inc(input logic [LOCK_CNT_W-1:0] v);
    logic [LOCK_CNT_W-1:0] r;
    if (v == {LOCK_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(LOCK_CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/otter_rr_pick2.sv
// Two-way round-robin picker: one-hot grant from two valids and the last winner.
// On contention the master that did not win last time is chosen.
module otter_rr_pick2
  import otter_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // Select one requester, alternating on a tie.
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_grant_i == M_AUX) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/otter_dmem_arbiter.sv
// Shares the OTTER data-memory port between the hart (M0) and an auxiliary master (M1)
// with round-robin arbitration, bounded locked sequences and 1-cycle read-data routing.
module otter_dmem_arbiter
  import otter_arb_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 32'd65536,
  parameter int unsigned MAX_LOCK = 32'd16
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic        m0_we,
  input  logic [3:0]  m0_strb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_lock,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic        m1_we,
  input  logic [3:0]  m1_strb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,

  output logic        dmem_r_en,
  output logic        dmem_w_en,
  output logic [3:0]  dmem_w_strb,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_w_data,
  input  logic [31:0] dmem_r_data
);

  // Addresses at or above MEM_SIZE are MMIO and pass through untouched.
  if ((MAX_LOCK < 32'd1) || (MAX_LOCK > 32'd255) || (MEM_SIZE < 32'd4)) begin : g_param_check
    $error("otter_dmem_arbiter: MAX_LOCK must be 1..255 and MEM_SIZE at least 4");
  end

  localparam logic [LOCK_CNT_W-1:0] MAX_LOCK_C = LOCK_CNT_W'(MAX_LOCK);

  arb_state_e            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_owner_q, rd_owner_d;

  logic [1:0]  pick_grant_s;
  logic [1:0]  grant_s;
  logic        acc_s;
  logic        acc_idx_s;
  logic        sel_we_s;
  logic        sel_lock_s;
  logic [3:0]  sel_strb_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic        owner_valid_s;
  logic        owner_lock_s;
  logic        waiter_valid_s;
  logic [LOCK_CNT_W-1:0] cnt_inc_s;

  otter_rr_pick2 u_pick (
    .valid_i      ({m1_valid, m0_valid}),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_grant_s)
  );

  // Grant: forced off in reset, owner-only while locked, round-robin when free.
  always_comb begin
    grant_s = 2'b00;
    if (!rst) begin
      grant_s = 2'b00;
    end else if (state_q == ARB_LOCKED) begin
      grant_s = (owner_q == M_AUX) ? {m1_valid, 1'b0} : {1'b0, m0_valid};
    end else begin
      grant_s = pick_grant_s;
    end
  end

  assign acc_s     = grant_s[0] | grant_s[1];
  assign acc_idx_s = grant_s[1];
  assign m0_ready  = grant_s[0];
  assign m1_ready  = grant_s[1];

  // Payload of the granted master; zero when nobody holds the grant.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_lock_s  = 1'b0;
    sel_strb_s  = 4'h0;
    sel_addr_s  = 32'h0;
    sel_wdata_s = 32'h0;
    case (grant_s)
      2'b01: begin
        sel_we_s    = m0_we;
        sel_lock_s  = m0_lock;
        sel_strb_s  = m0_strb;
        sel_addr_s  = m0_addr;
        sel_wdata_s = m0_wdata;
      end
      2'b10: begin
        sel_we_s    = m1_we;
        sel_lock_s  = m1_lock;
        sel_strb_s  = m1_strb;
        sel_addr_s  = m1_addr;
        sel_wdata_s = m1_wdata;
      end
      default: begin
        sel_we_s    = 1'b0;
        sel_lock_s  = 1'b0;
        sel_strb_s  = 4'h0;
        sel_addr_s  = 32'h0;
        sel_wdata_s = 32'h0;
      end
    endcase
  end

  // Memory port drive; strobes only meaningful on writes.
  always_comb begin
    dmem_r_en   = acc_s & ~sel_we_s;
    dmem_w_en   = acc_s & sel_we_s;
    dmem_addr   = sel_addr_s;
    dmem_w_data = sel_wdata_s;
    if (acc_s && sel_we_s) begin
      dmem_w_strb = sel_strb_s;
    end else begin
      dmem_w_strb = 4'h0;
    end
  end

  assign owner_valid_s  = (owner_q == M_AUX) ? m1_valid : m0_valid;
  assign owner_lock_s   = (owner_q == M_AUX) ? m1_lock  : m0_lock;
  assign waiter_valid_s = (owner_q == M_AUX) ? m0_valid : m1_valid;
  assign cnt_inc_s      = sat_inc(lock_cnt_q);

  // Next-state: lock entry/exit, lock timeout, and read-return bookkeeping.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    lock_cnt_d   = lock_cnt_q;
    rd_pend_d    = 1'b0;
    rd_owner_d   = rd_owner_q;

    case (state_q)
      ARB_FREE: begin
        lock_cnt_d = {LOCK_CNT_W{1'b0}};
        if (acc_s) begin
          last_grant_d = acc_idx_s;
          if (sel_lock_s) begin
            state_d = ARB_LOCKED;
            owner_d = acc_idx_s;
          end else begin
            state_d = ARB_FREE;
          end
        end else begin
          state_d = ARB_FREE;
        end
      end
      ARB_LOCKED: begin
        if (waiter_valid_s) begin
          lock_cnt_d = cnt_inc_s;
        end else begin
          lock_cnt_d = lock_cnt_q;
        end
        // On timeout the owner counts as last winner so the waiter takes the next slot.
        if (waiter_valid_s && (cnt_inc_s >= MAX_LOCK_C)) begin
          state_d      = ARB_FREE;
          last_grant_d = owner_q;
          lock_cnt_d   = {LOCK_CNT_W{1'b0}};
        end else if (acc_s) begin
          last_grant_d = owner_q;
          if (!sel_lock_s) begin
            state_d    = ARB_FREE;
            lock_cnt_d = {LOCK_CNT_W{1'b0}};
          end else begin
            state_d = ARB_LOCKED;
          end
        end else if (!owner_valid_s && !owner_lock_s) begin
          state_d    = ARB_FREE;
          lock_cnt_d = {LOCK_CNT_W{1'b0}};
        end else begin
          state_d = ARB_LOCKED;
        end
      end
      default: begin
        state_d    = ARB_FREE;
        lock_cnt_d = {LOCK_CNT_W{1'b0}};
      end
    endcase

    if (acc_s && !sel_we_s) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = acc_idx_s;
    end else begin
      rd_pend_d  = 1'b0;
    end
  end

  // State registers; reset makes M0 the winner of the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_FREE;
      owner_q      <= M_HART;
      last_grant_q <= M_AUX;
      lock_cnt_q   <= {LOCK_CNT_W{1'b0}};
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= M_HART;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // Route the returning read word only to the master that issued the read.
  always_comb begin
    m0_rvalid = 1'b0;
    m0_rdata  = 32'h0;
    m1_rvalid = 1'b0;
    m1_rdata  = 32'h0;
    if (rd_pend_q && (rd_owner_q == M_HART)) begin
      m0_rvalid = 1'b1;
      m0_rdata  = dmem_r_data;
    end else if (rd_pend_q && (rd_owner_q == M_AUX)) begin
      m1_rvalid = 1'b1;
      m1_rdata  = dmem_r_data;
    end else begin
      m0_rvalid = 1'b0;
      m1_rvalid = 1'b0;
    end
  end

endmodule
